// File: rtl/btn_pkg.sv
// Shared definitions for the button gesture block: FSM state encoding,
// click-count width and saturation value, and the saturating count helper.
// Ports: none (package).
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DOWN      = 2'd1,
    ST_UP_WAIT   = 2'd2,
    ST_LONG_HELD = 2'd3
  } gesture_state_e;

  localparam int unsigned     CNT_W     = 3;
  localparam logic [CNT_W-1:0] COUNT_MAX = 3'd7;

  // Click counter increment that sticks at COUNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] count_inc(input logic [CNT_W-1:0] c);
    return (c == COUNT_MAX) ? COUNT_MAX : c + 1'b1;
  endfunction

endpackage

// File: rtl/btn_sync_db.sv
// Purpose: synchronise the raw active-low button and debounce it into a level.
// Latency: 2 sync cycles + DB_CYCLES stable cycles until pressed changes.
// Backpressure: none; free-running, no handshake.
// Ports: clk/rst (async active-high); nbtn raw button (active low, async);
//        pressed debounced level (registered); rise/fall one-cycle strobes
//        that are high on the cycle whose closing edge flips pressed.
module btn_sync_db #(
  parameter int unsigned DB_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic nbtn,
  output logic pressed,
  output logic rise,
  output logic fall
);

  localparam int unsigned      DB_W    = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            meta_q, meta_d;
  logic            sync_q, sync_d;
  logic            pressed_q, pressed_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            flip;

  always_comb begin
    // Invert first so everything downstream is active-high.
    meta_d = ~nbtn;
    sync_d = meta_q;

    // db_cnt_q counts consecutive disagreeing cycles already seen; the
    // DB_CYCLES-th disagreeing cycle flips the level on its closing edge.
    flip      = (sync_q != pressed_q) && (db_cnt_q == DB_LAST);
    pressed_d = flip ? sync_q : pressed_q;

    if ((sync_q == pressed_q) || flip) begin
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      pressed_q <= 1'b0;
      db_cnt_q  <= '0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      pressed_q <= pressed_d;
      db_cnt_q  <= db_cnt_d;
    end
  end

  // Strobes lead pressed by one cycle so the gesture FSM changes state on
  // the same edge that the debounced level changes.
  assign rise    = flip &  sync_q;
  assign fall    = flip & ~sync_q;
  assign pressed = pressed_q;

endmodule

// File: rtl/btn_gesture.sv
// Purpose: classify a debounced button into multi-click gestures and long presses.
// Latency: click_valid GAP_CYCLES after the last debounced release; long_press LONG_CYCLES after the debounced press.
// Backpressure: none; outputs are single-cycle pulses with no handshake.
// Ports: clk/rst (async active-high); nbtn raw active-low button; pressed
//        debounced level; click_valid + click_count (0 when not valid);
//        long_press pulse. All outputs registered.
module btn_gesture
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 65536,
  parameter int unsigned GAP_CYCLES  = 4000000,
  parameter int unsigned LONG_CYCLES = 16000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nbtn,
  output logic             pressed,
  output logic             click_valid,
  output logic [CNT_W-1:0] click_count,
  output logic             long_press
);

  // One shared timer; LONG_CYCLES is the largest terminal value it must reach.
  localparam int unsigned       TMR_W     = $clog2(LONG_CYCLES);
  localparam logic [TMR_W-1:0]  GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LONG_LAST = TMR_W'(LONG_CYCLES - 1);

  logic pressed_lvl;
  logic rise;
  logic fall;

  btn_sync_db #(
    .DB_CYCLES (DB_CYCLES)
  ) u_sync_db (
    .clk     (clk),
    .rst     (rst),
    .nbtn    (nbtn),
    .pressed (pressed_lvl),
    .rise    (rise),
    .fall    (fall)
  );

  gesture_state_e   state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             click_valid_q, click_valid_d;
  logic [CNT_W-1:0] click_count_q, click_count_d;
  logic             long_press_q, long_press_d;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q + 1'b1;
    count_d       = count_q;
    click_valid_d = 1'b0;
    click_count_d = '0;
    long_press_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (rise) begin
          state_d = ST_DOWN;
          count_d = CNT_W'(1);
        end
      end

      ST_DOWN: begin
        if (pressed_lvl && (timer_q == LONG_LAST)) begin
          // Long press wins over a release landing on the same cycle; in
          // that case the release is already consumed, so skip LONG_HELD.
          long_press_d = 1'b1;
          count_d      = '0;
          timer_d      = '0;
          state_d      = fall ? ST_IDLE : ST_LONG_HELD;
        end else if (fall) begin
          state_d = ST_UP_WAIT;
          timer_d = '0;
        end
      end

      ST_UP_WAIT: begin
        // A new press on the timeout cycle continues the gesture.
        if (rise) begin
          state_d = ST_DOWN;
          timer_d = '0;
          count_d = count_inc(count_q);
        end else if (timer_q == GAP_LAST) begin
          click_valid_d = 1'b1;
          click_count_d = count_q;
          state_d       = ST_IDLE;
          timer_d       = '0;
        end
      end

      ST_LONG_HELD: begin
        timer_d = '0;
        if (fall) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      count_q       <= '0;
      click_valid_q <= 1'b0;
      click_count_q <= '0;
      long_press_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      count_q       <= count_d;
      click_valid_q <= click_valid_d;
      click_count_q <= click_count_d;
      long_press_q  <= long_press_d;
    end
  end

  assign pressed     = pressed_lvl;
  assign click_valid = click_valid_q;
  assign click_count = click_count_q;
  assign long_press  = long_press_q;

endmodule

// File: tb/tb_btn_gesture.sv
// Bench for btn_gesture with short timing parameters. A reference model
// follows the raw button through a two-cycle delay and a run-length debounce,
// then turns press/release timestamps into expected pulses.
module tb_btn_gesture;

  localparam int DB   = 4;
  localparam int GAP  = 20;
  localparam int LONG = 50;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       nbtn = 1'b1;
  logic       pressed;
  logic       click_valid;
  logic [2:0] click_count;
  logic       long_press;

  btn_gesture #(
    .DB_CYCLES   (DB),
    .GAP_CYCLES  (GAP),
    .LONG_CYCLES (LONG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .nbtn        (nbtn),
    .pressed     (pressed),
    .click_valid (click_valid),
    .click_count (click_count),
    .long_press  (long_press)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int tcyc     = 0;

  always @(posedge clk) tcyc <= tcyc + 1;

  // ---------------- reference model ----------------
  logic       m_meta = 1'b0, m_sync = 1'b0, m_pressed = 1'b0;
  logic       m_np = 1'b0, m_was = 1'b0;
  logic       exp_cv = 1'b0, exp_lp = 1'b0;
  logic [2:0] exp_cc = 3'd0;
  int         m_run = 0, m_cyc = 0, m_pr = 0, m_pf = 0, m_clicks = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_meta = 1'b0; m_sync = 1'b0; m_pressed = 1'b0;
      m_run = 0; m_cyc = 0; m_pr = 0; m_pf = 0; m_clicks = 0;
      exp_cv = 1'b0; exp_cc = 3'd0; exp_lp = 1'b0;
    end else begin
      m_cyc++;
      // Level flips after DB consecutive cycles of disagreement.
      if (m_sync != m_pressed) m_run++; else m_run = 0;
      m_np = m_pressed;
      if (m_run == DB) begin
        m_np  = m_sync;
        m_run = 0;
      end
      m_sync = m_meta;
      m_meta = ~nbtn;
      m_was  = m_pressed;
      exp_cv = 1'b0; exp_cc = 3'd0; exp_lp = 1'b0;
      if (m_np && !m_was) begin
        // Release of at most GAP cycles keeps the gesture going.
        if (m_clicks > 0 && (m_cyc - m_pf) <= GAP)
          m_clicks = (m_clicks >= 7) ? 7 : m_clicks + 1;
        else
          m_clicks = 1;
        m_pr = m_cyc;
      end
      if (!m_np && m_was) m_pf = m_cyc;
      // Held for LONG full cycles -> long press, gesture discarded.
      if (m_was && (m_cyc - m_pr) == LONG) begin
        exp_lp   = 1'b1;
        m_clicks = 0;
      end
      m_pressed = m_np;
      if (!m_pressed && m_clicks > 0 && (m_cyc - m_pf) == GAP) begin
        exp_cv   = 1'b1;
        exp_cc   = 3'(m_clicks);
        m_clicks = 0;
      end
    end
  end

  // ---------------- observation ----------------
  int         mon_bad, first_bad_cyc, viol;
  logic [5:0] first_act, first_exp;
  int         n_cv, cv_cyc, n_lp, lp_cyc, n_rise, rise_cyc, n_fall, fall_cyc;
  logic [2:0] last_cc;
  logic       prev_p, prev_cv, prev_lp;

  task automatic clear_obs();
    mon_bad = 0; first_bad_cyc = 0; viol = 0; first_act = '0; first_exp = '0;
    n_cv = 0; cv_cyc = 0; n_lp = 0; lp_cyc = 0;
    n_rise = 0; rise_cyc = 0; n_fall = 0; fall_cyc = 0;
    last_cc = 3'd0; prev_p = 1'b0; prev_cv = 1'b0; prev_lp = 1'b0;
  endtask

  task automatic sample();
    logic [5:0] act_v, exp_v;
    act_v = {pressed, click_valid, click_count, long_press};
    exp_v = {m_pressed, exp_cv, exp_cc, exp_lp};
    if (act_v !== exp_v) begin
      mon_bad++;
      if (mon_bad == 1) begin
        first_bad_cyc = tcyc; first_act = act_v; first_exp = exp_v;
      end
    end
    if (click_valid && long_press) viol++;
    if (click_valid && prev_cv) viol++;
    if (long_press && prev_lp) viol++;
    if (click_valid) begin n_cv++; last_cc = click_count; cv_cyc = tcyc; end
    if (long_press) begin n_lp++; lp_cyc = tcyc; end
    if (pressed && !prev_p) begin n_rise++; rise_cyc = tcyc; end
    if (!pressed && prev_p) begin n_fall++; fall_cyc = tcyc; end
    prev_p = pressed; prev_cv = click_valid; prev_lp = long_press;
  endtask

  // Drive nbtn=lvl for n cycles; entered and left at 1 time unit after posedge.
  task automatic hold(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      nbtn = lvl;
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pressed !== 1'b0) begin failures++; $display("FAIL reset_pressed: got %b expected 0", pressed); end
    checks++;
    if (click_valid !== 1'b0) begin failures++; $display("FAIL reset_click_valid: got %b expected 0", click_valid); end
    checks++;
    if (click_count !== 3'd0) begin failures++; $display("FAIL reset_click_count: got %0d expected 0", click_count); end
    checks++;
    if (long_press !== 1'b0) begin failures++; $display("FAIL reset_long_press: got %b expected 0", long_press); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_obs();
    hold(1'b1, 10);
    checks++;
    if (mon_bad !== 0) begin failures++; $display("FAIL reset_idle_model: %0d cycles differ, first cycle %0d got %b expected %b", mon_bad, first_bad_cyc, first_act, first_exp); end
  endtask

  task automatic test_bounce();
    int lo_start;
    clear_obs();
    lo_start = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 28) lo_start = tcyc;
      hold(((i / 2) % 2 == 0) ? 1'b0 : 1'b1, 1);
    end
    hold(1'b0, 20);
    checks++;
    if (n_rise !== 1) begin failures++; $display("FAIL bounce_rise_count: got %0d expected 1", n_rise); end
    checks++;
    if (n_fall !== 0) begin failures++; $display("FAIL bounce_fall_count: got %0d expected 0", n_fall); end
    checks++;
    if (rise_cyc - lo_start !== 6) begin failures++; $display("FAIL bounce_rise_latency: got %0d expected 6", rise_cyc - lo_start); end
    hold(1'b1, 40);
    checks++;
    if (mon_bad !== 0) begin failures++; $display("FAIL bounce_model: %0d cycles differ, first cycle %0d got %b expected %b", mon_bad, first_bad_cyc, first_act, first_exp); end
  endtask

  task automatic test_single_click();
    clear_obs();
    hold(1'b0, 10);
    hold(1'b1, 40);
    checks++;
    if (n_cv !== 1) begin failures++; $display("FAIL single_click_pulses: got %0d expected 1", n_cv); end
    checks++;
    if (last_cc !== 3'd1) begin failures++; $display("FAIL single_click_count: got %0d expected 1", last_cc); end
    checks++;
    if (cv_cyc - fall_cyc !== GAP) begin failures++; $display("FAIL single_click_latency: got %0d expected %0d", cv_cyc - fall_cyc, GAP); end
    checks++;
    if (mon_bad !== 0) begin failures++; $display("FAIL single_click_model: %0d cycles differ, first cycle %0d got %b expected %b", mon_bad, first_bad_cyc, first_act, first_exp); end
  endtask

  task automatic test_triple_click();
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      hold(1'b0, 10);
      hold(1'b1, 8);
    end
    hold(1'b1, 40);
    checks++;
    if (n_cv !== 1) begin failures++; $display("FAIL triple_click_pulses: got %0d expected 1", n_cv); end
    checks++;
    if (last_cc !== 3'd3) begin failures++; $display("FAIL triple_click_count: got %0d expected 3", last_cc); end
    checks++;
    if (cv_cyc - fall_cyc !== GAP) begin failures++; $display("FAIL triple_click_latency: got %0d expected %0d", cv_cyc - fall_cyc, GAP); end
    checks++;
    if (mon_bad !== 0) begin failures++; $display("FAIL triple_click_model: %0d cycles differ, first cycle %0d got %b expected %b", mon_bad, first_bad_cyc, first_act, first_exp); end
  endtask

  task automatic test_long_press();
    clear_obs();
    hold(1'b0, 80);
    hold(1'b1, 60);
    checks++;
    if (n_lp !== 1) begin failures++; $display("FAIL long_press_pulses: got %0d expected 1", n_lp); end
    checks++;
    if (lp_cyc - rise_cyc !== LONG) begin failures++; $display("FAIL long_press_latency: got %0d expected %0d", lp_cyc - rise_cyc, LONG); end
    checks++;
    if (n_cv !== 0) begin failures++; $display("FAIL long_press_no_click: got %0d expected 0", n_cv); end
    checks++;
    if (mon_bad !== 0) begin failures++; $display("FAIL long_press_model: %0d cycles differ, first cycle %0d got %b expected %b", mon_bad, first_bad_cyc, first_act, first_exp); end
  endtask

  task automatic test_saturate();
    clear_obs();
    for (int i = 0; i < 9; i++) begin
      hold(1'b0, 6);
      hold(1'b1, 6);
    end
    hold(1'b1, 40);
    checks++;
    if (n_cv !== 1) begin failures++; $display("FAIL saturate_pulses: got %0d expected 1", n_cv); end
    checks++;
    if (last_cc !== 3'd7) begin failures++; $display("FAIL saturate_count: got %0d expected 7", last_cc); end
  endtask

  task automatic test_gap_boundary();
    // Release of exactly GAP cycles: new press lands on the timeout cycle.
    clear_obs();
    hold(1'b0, 10); hold(1'b1, GAP); hold(1'b0, 10); hold(1'b1, 40);
    checks++;
    if (n_cv !== 1 || last_cc !== 3'd2) begin failures++; $display("FAIL gap_edge_continue: got %0d pulses count %0d expected 1 pulse count 2", n_cv, last_cc); end
    // One cycle longer: the first gesture times out on its own.
    clear_obs();
    hold(1'b0, 10); hold(1'b1, GAP + 1); hold(1'b0, 10); hold(1'b1, 40);
    checks++;
    if (n_cv !== 2 || last_cc !== 3'd1) begin failures++; $display("FAIL gap_edge_split: got %0d pulses count %0d expected 2 pulses count 1", n_cv, last_cc); end
  endtask

  task automatic test_reset_mid_gesture();
    logic [5:0] outs;
    clear_obs();
    hold(1'b0, 10); hold(1'b1, 8); hold(1'b0, 10); hold(1'b1, 12);
    rst = 1'b1;
    #1;
    outs = {pressed, click_valid, click_count, long_press};
    checks++;
    if (outs !== 6'd0) begin failures++; $display("FAIL reset_mid_outputs: got %b expected 000000", outs); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hold(1'b1, 60);
    checks++;
    if (n_cv !== 0) begin failures++; $display("FAIL reset_mid_no_click: got %0d expected 0", n_cv); end
  endtask

  task automatic test_reset_held();
    int rel;
    clear_obs();
    hold(1'b0, 30);
    rst = 1'b1;
    #1;
    checks++;
    if (pressed !== 1'b0) begin failures++; $display("FAIL reset_held_async: got %b expected 0", pressed); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rel = tcyc;
    clear_obs();
    hold(1'b0, 20);
    checks++;
    if (n_rise !== 1 || rise_cyc - rel !== 2 + DB) begin failures++; $display("FAIL reset_held_rise: got %0d rises at offset %0d expected 1 at %0d", n_rise, rise_cyc - rel, 2 + DB); end
    hold(1'b1, 60);
    checks++;
    if (mon_bad !== 0) begin failures++; $display("FAIL reset_held_model: %0d cycles differ, first cycle %0d got %b expected %b", mon_bad, first_bad_cyc, first_act, first_exp); end
  endtask

  task automatic test_random();
    clear_obs();
    for (int i = 0; i < 60; i++) begin
      hold(1'b0, $urandom_range(1, 60));
      hold(1'b1, $urandom_range(1, 35));
    end
    hold(1'b1, 80);
    checks++;
    if (mon_bad !== 0) begin failures++; $display("FAIL random_model: %0d cycles differ, first cycle %0d got %b expected %b", mon_bad, first_bad_cyc, first_act, first_exp); end
    checks++;
    if (viol !== 0) begin failures++; $display("FAIL random_pulse_shape: got %0d violations expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_single_click();
    test_triple_click();
    test_long_press();
    test_saturate();
    test_gap_boundary();
    test_reset_mid_gesture();
    test_reset_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
